// File: rtl/width_12to8.sv
// Repacks a valid/ready stream of 12-bit words into 8-bit bytes, MSB-first.
// Two words become three bytes; leftover nibbles wait in a left-aligned buffer.
module width_12to8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  output logic        ready_in,
  input  logic [11:0] data_in,
  output logic        valid_out,
  input  logic        ready_out,
  output logic [7:0]  data_out
);

  logic [23:0] bit_buf;
  logic [2:0]  cnt;
  logic        in_fire;
  logic        out_fire;
  logic [2:0]  rem;
  logic [2:0]  cnt_next;
  logic [23:0] buf_shift;
  logic [23:0] buf_next;

  // Drops a word into the 12 bits directly below the remaining valid nibbles.
  function automatic logic [23:0] insert_word(input logic [23:0] b,
                                              input logic [2:0]  r,
                                              input logic [11:0] w);
    logic [23:0] o;
    o = b;
    case (r)
      3'd0:    o[23:12] = w;
      3'd1:    o[19:8]  = w;
      3'd2:    o[15:4]  = w;
      default: o[11:0]  = w;
    endcase
    return o;
  endfunction

  assign valid_out = (cnt >= 3'd2);
  assign ready_in  = (cnt <= 3'd3);
  assign data_out  = bit_buf[23:16];

  always_comb begin
    in_fire   = valid_in & ready_in;
    out_fire  = valid_out & ready_out;
    rem       = out_fire ? (cnt - 3'd2) : cnt;
    buf_shift = out_fire ? {bit_buf[15:0], 8'h00} : bit_buf;
    buf_next  = in_fire ? insert_word(buf_shift, rem, data_in) : buf_shift;
    cnt_next  = cnt + (in_fire ? 3'd3 : 3'd0) - (out_fire ? 3'd2 : 3'd0);
  end

  // Buffer is cleared on reset too, so data_out reads 0x00 afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 3'd0;
      bit_buf <= 24'h0;
    end else begin
      cnt     <= cnt_next;
      bit_buf <= buf_next;
    end
  end

endmodule

// File: tb/tb_width_12to8.sv
// Bench for width_12to8: nibble-queue reference model plus directed and random streams.
module tb_width_12to8;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        ready_in;
  logic [11:0] data_in;
  logic        valid_out;
  logic        ready_out;
  logic [7:0]  data_out;

  logic [3:0]  mq[$];
  logic [7:0]  got[$];
  logic [7:0]  exp_b[$];
  int          n_checks = 0;
  int          n_fail = 0;

  width_12to8 dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
    .data_in(data_in), .valid_out(valid_out), .ready_out(ready_out),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {ready_in, valid_out, data_out} from the queued nibbles.
  function automatic logic [9:0] model_out();
    logic [7:0] b;
    b = 8'h00;
    if (mq.size() > 0) b[7:4] = mq[0];
    if (mq.size() > 1) b[3:0] = mq[1];
    return {mq.size() <= 3, mq.size() >= 2, b};
  endfunction

  // Expected byte stream: plain MSB-first bit concatenation of the words.
  function automatic void build_bytes(input logic [11:0] ws[$]);
    logic bq[$];
    logic [7:0] b;
    exp_b.delete();
    foreach (ws[i]) for (int k = 11; k >= 0; k--) bq.push_back(ws[i][k]);
    while (bq.size() >= 8) begin
      for (int k = 7; k >= 0; k--) b[k] = bq.pop_front();
      exp_b.push_back(b);
    end
  endfunction

  function automatic bit same_stream();
    if (got.size() != exp_b.size()) return 1'b0;
    foreach (got[i]) if (got[i] !== exp_b[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Drive one cycle from a negedge, capture accepted bytes, advance the model.
  task automatic step(input logic r, input logic v, input logic [11:0] d,
                      input logic ro, output logic acc);
    logic inf, outf;
    rst = r; valid_in = v; data_in = d; ready_out = ro;
    if (!r && valid_out && ro) got.push_back(data_out);
    inf  = !r && v && (mq.size() <= 3);
    outf = !r && ro && (mq.size() >= 2);
    @(posedge clk);
    if (r) begin
      mq.delete();
      got.delete();
    end else begin
      if (outf) begin
        void'(mq.pop_front());
        void'(mq.pop_front());
      end
      if (inf) begin
        mq.push_back(d[11:8]);
        mq.push_back(d[7:4]);
        mq.push_back(d[3:0]);
      end
    end
    acc = inf;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic acc;
    step(1'b1, 1'b0, 12'h0, 1'b0, acc);
    n_checks++;
    if ({ready_in, valid_out, data_out} !== 10'b1_0_00000000) begin
      n_fail++;
      $display("FAIL reset_state got=%b required=%b", {ready_in, valid_out, data_out}, 10'b1_0_00000000);
    end
  endtask

  task automatic test_basic();
    logic acc;
    logic [11:0] w[2] = '{12'hABC, 12'hDEF};
    step(1'b1, 1'b0, 12'h0, 1'b1, acc);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({ready_in, valid_out, data_out} !== model_out()) begin
        n_fail++;
        $display("FAIL basic_cycle%0d got=%h required=%h", i, {ready_in, valid_out, data_out}, model_out());
      end
      step(1'b0, i < 2, (i < 2) ? w[i] : 12'h0, 1'b1, acc);
    end
    exp_b = '{8'hAB, 8'hCD, 8'hEF};
    n_checks++;
    if (!same_stream() || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_stream got=%p valid_out=%b required=%p valid_out=0", got, valid_out, exp_b);
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    step(1'b1, 1'b0, 12'h0, 1'b0, acc);
    step(1'b0, 1'b1, 12'h123, 1'b0, acc);
    n_checks++;
    if (ready_in !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_after_first got=%b required=1", ready_in);
    end
    step(1'b0, 1'b1, 12'h456, 1'b0, acc);
    n_checks++;
    if (ready_in !== 1'b0 || valid_out !== 1'b1 || data_out !== 8'h12) begin
      n_fail++;
      $display("FAIL bp_full got=%b%b%h required=1 0 12 (valid ready data)", valid_out, ready_in, data_out);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({ready_in, valid_out, data_out} !== model_out()) begin
        n_fail++;
        $display("FAIL bp_hold%0d got=%h required=%h", i, {ready_in, valid_out, data_out}, model_out());
      end
      step(1'b0, 1'b1, 12'h789, 1'b0, acc);
    end
    acc = 1'b0;
    for (int i = 0; i < 12 && !acc; i++) begin
      n_checks++;
      if ({ready_in, valid_out, data_out} !== model_out()) begin
        n_fail++;
        $display("FAIL bp_drain%0d got=%h required=%h", i, {ready_in, valid_out, data_out}, model_out());
      end
      step(1'b0, 1'b1, 12'h789, 1'b1, acc);
    end
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL bp_accept_timeout got=not_accepted required=accepted");
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 12'h0, 1'b1, acc);
    exp_b = '{8'h12, 8'h34, 8'h56, 8'h78};
    n_checks++;
    if (!same_stream()) begin
      n_fail++;
      $display("FAIL bp_stream got=%p required=%p", got, exp_b);
    end
  endtask

  task automatic test_residue();
    logic acc;
    step(1'b1, 1'b0, 12'h0, 1'b1, acc);
    step(1'b0, 1'b1, 12'h9A5, 1'b1, acc);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({ready_in, valid_out, data_out} !== model_out()) begin
        n_fail++;
        $display("FAIL residue_idle%0d got=%h required=%h", i, {ready_in, valid_out, data_out}, model_out());
      end
      step(1'b0, 1'b0, 12'h0, 1'b1, acc);
    end
    exp_b = '{8'h9A};
    n_checks++;
    if (!same_stream() || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL residue_hold got=%p valid_out=%b required=%p valid_out=0", got, valid_out, exp_b);
    end
    step(1'b0, 1'b1, 12'hBCD, 1'b1, acc);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 12'h0, 1'b1, acc);
    exp_b = '{8'h9A, 8'h5B, 8'hCD};
    n_checks++;
    if (!same_stream()) begin
      n_fail++;
      $display("FAIL residue_stream got=%p required=%p", got, exp_b);
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic [11:0] ws[$];
    int idx = 0;
    for (int i = 1; i <= 16; i++) ws.push_back(12'(i));
    step(1'b1, 1'b0, 12'h0, 1'b1, acc);
    for (int c = 0; c < 60 && (idx < 16 || mq.size() >= 2); c++) begin
      n_checks++;
      if ({ready_in, valid_out, data_out} !== model_out()) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d got=%h required=%h", c, {ready_in, valid_out, data_out}, model_out());
      end
      step(1'b0, idx < 16, (idx < 16) ? ws[idx] : 12'h0, 1'b1, acc);
      if (acc) idx++;
    end
    build_bytes(ws);
    n_checks++;
    if (!same_stream() || exp_b.size() != 24) begin
      n_fail++;
      $display("FAIL b2b_stream got=%p required=%p", got, exp_b);
    end
  endtask

  task automatic test_mid_reset();
    logic acc;
    step(1'b1, 1'b0, 12'h0, 1'b1, acc);
    step(1'b0, 1'b1, 12'hFFF, 1'b0, acc);
    n_checks++;
    if ({ready_in, valid_out, data_out} !== 10'b1_1_11111111) begin
      n_fail++;
      $display("FAIL midrst_before got=%b required=%b", {ready_in, valid_out, data_out}, 10'b1_1_11111111);
    end
    step(1'b1, 1'b1, 12'hAAA, 1'b1, acc);
    n_checks++;
    if ({ready_in, valid_out, data_out} !== 10'b1_0_00000000) begin
      n_fail++;
      $display("FAIL midrst_after got=%b required=%b", {ready_in, valid_out, data_out}, 10'b1_0_00000000);
    end
    step(1'b0, 1'b1, 12'h3C3, 1'b1, acc);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 12'h0, 1'b1, acc);
    exp_b = '{8'h3C};
    n_checks++;
    if (!same_stream() || {ready_in, valid_out, data_out} !== model_out()) begin
      n_fail++;
      $display("FAIL midrst_stream got=%p out=%h required=%p out=%h", got, {ready_in, valid_out, data_out}, exp_b, model_out());
    end
  endtask

  task automatic test_random();
    logic acc;
    logic v, ro;
    logic [11:0] ws[$];
    int idx = 0;
    int c = 0;
    for (int i = 0; i < 2000; i++) ws.push_back(12'($urandom));
    step(1'b1, 1'b0, 12'h0, 1'b0, acc);
    while ((idx < 2000 || mq.size() >= 2) && c < 20000) begin
      v  = (idx < 2000) ? 1'($urandom_range(0, 1)) : 1'b0;
      ro = (idx < 2000) ? 1'($urandom_range(0, 1)) : 1'b1;
      n_checks++;
      if ({ready_in, valid_out, data_out} !== model_out() || dut.cnt > 3'd6) begin
        n_fail++;
        $display("FAIL rand_cycle%0d got=%h cnt=%0d required=%h", c, {ready_in, valid_out, data_out}, dut.cnt, model_out());
      end
      step(1'b0, v, (idx < 2000) ? ws[idx] : 12'h0, ro, acc);
      if (acc) idx++;
      c++;
    end
    build_bytes(ws);
    n_checks++;
    if (!same_stream() || idx != 2000) begin
      n_fail++;
      $display("FAIL rand_stream got_bytes=%0d words=%0d required_bytes=%0d words=2000", got.size(), idx, exp_b.size());
    end
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; data_in = 12'h0; ready_out = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_residue();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
